// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller with memory-wait timeout FSM
// Optional PERF_CNT_EN enables saturating load-use / mem-wait / flush performance counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_mem_access,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_d;
  logic       mem_stall, load_use;

  assign mem_stall = exmem_mem_access && !dmem_ready;
  assign load_use  = idex_memread && (idex_rd != 5'd0) &&
                     ((ifid_uses_rs1 && (idex_rd == ifid_rs1)) ||
                      (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mem_err <= err_d;
    end
  end

  // wait_q counts stalled cycles of the current access, including the first one seen in RUN
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = mem_err;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q < WAIT_LAST) begin
          wait_d = wait_q + 8'd1;
        end else begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (rst_n) begin
      if (state_q == HALT || mem_stall) begin
        pipe_hold = 1'b1;
      end else if (branch_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic lu_act, mw_act, fl_act;

  assign mw_act = (state_q != HALT) && mem_stall;
  assign fl_act = (state_q != HALT) && !mem_stall && branch_taken;
  assign lu_act = (state_q != HALT) && !mem_stall && !branch_taken && load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt <= '0;
      mem_wait_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (lu_act && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + 1'b1;
      if (mw_act && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + 1'b1;
      if (fl_act && (flush_cnt != '1))    flush_cnt    <= flush_cnt + 1'b1;
    end
  end
`else
  assign load_use_cnt = '0;
  assign mem_wait_cnt = '0;
  assign flush_cnt    = '0;
`endif

endmodule
